// File: rtl/qspi_master.sv
// qspi_master: quad-SPI initiator, one byte per command, sent or received as
// two nibbles (high nibble first), one QCK period per nibble. Every pin is
// driven straight from a flop, so the pins cannot glitch.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | bus released (qss=1), waiting for a command
//   SELECT   | qss asserted, setup time before the first nibble
//   LOW0     | qck low, high nibble presented (write) or bus released (read)
//   HIGH0    | qck high, high nibble sampled on the last cycle
//   LOW1     | qck low, low nibble presented
//   HIGH1    | qck high, low nibble sampled on the last cycle
//   SEL_WAIT | qss held low between bytes of a session, waiting for a command
//   DESELECT | qss held low for one more half-period before release
module qspi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       io_mainClk,
  input  logic       io_asyncReset,
  input  logic       io_cmd_valid,
  output logic       io_cmd_ready,
  input  logic       io_cmd_write,
  input  logic [7:0] io_cmd_data,
  input  logic       io_cmd_last,
  output logic       io_rsp_valid,
  output logic [7:0] io_rsp_data,
  output logic       io_busy,
  output logic       io_qspi_qss,
  output logic       io_qspi_qck,
  output logic [3:0] io_qspi_qd_write,
  output logic [3:0] io_qspi_qd_writeEnable,
  input  logic [3:0] io_qspi_qd_read
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_LOW0     = 3'd2;
  localparam logic [2:0] ST_HIGH0    = 3'd3;
  localparam logic [2:0] ST_LOW1     = 3'd4;
  localparam logic [2:0] ST_HIGH1    = 3'd5;
  localparam logic [2:0] ST_SEL_WAIT = 3'd6;
  localparam logic [2:0] ST_DESELECT = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic [3:0]    rd_hi_q, rd_hi_d;
  logic          qss_q, qss_d;
  logic          qck_q, qck_d;
  logic [3:0]    qd_q, qd_d;
  logic [3:0]    oe_q, oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;

  logic accept;
  logic phase_done;
  logic state_change;

  assign io_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_SEL_WAIT);
  assign accept       = io_cmd_valid && io_cmd_ready;
  assign phase_done   = (cnt_q == '0);
  assign io_busy      = (state_q != ST_IDLE);

  assign io_qspi_qss            = qss_q;
  assign io_qspi_qck            = qck_q;
  assign io_qspi_qd_write       = qd_q;
  assign io_qspi_qd_writeEnable = oe_q;
  assign io_rsp_valid           = rsp_valid_q;
  assign io_rsp_data            = rsp_data_q;

  // Sequencing: command latch and state transitions.
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    data_d  = data_q;
    last_d  = last_q;
    if (accept) begin
      write_d = io_cmd_write;
      data_d  = io_cmd_data;
      last_d  = io_cmd_last;
    end
    case (state_q)
      ST_IDLE:     if (accept)     state_d = ST_SELECT;
      ST_SELECT:   if (phase_done) state_d = ST_LOW0;
      ST_LOW0:     if (phase_done) state_d = ST_HIGH0;
      ST_HIGH0:    if (phase_done) state_d = ST_LOW1;
      ST_LOW1:     if (phase_done) state_d = ST_HIGH1;
      ST_HIGH1:    if (phase_done) state_d = last_q ? ST_DESELECT : ST_SEL_WAIT;
      ST_SEL_WAIT: if (accept)     state_d = ST_LOW0;
      ST_DESELECT: if (phase_done) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Half-period down-counter, reloaded on every state entry.
  always_comb begin
    if (state_change)       cnt_d = CNT_LOAD;
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
    else                    cnt_d = cnt_q;
  end

  // Pin values are computed from the next state so they line up with it.
  // QD only moves on LOW-phase entry, giving a full half-period of setup.
  always_comb begin
    qss_d = (state_d == ST_IDLE);
    qck_d = (state_d == ST_HIGH0) || (state_d == ST_HIGH1);
    qd_d  = qd_q;
    oe_d  = oe_q;
    if (state_change && state_d == ST_LOW0) begin
      oe_d = write_d ? 4'hF : 4'h0;
      if (write_d) qd_d = data_d[7:4];
    end else if (state_change && state_d == ST_LOW1) begin
      oe_d = write_d ? 4'hF : 4'h0;
      if (write_d) qd_d = data_d[3:0];
    end else if (state_d != ST_LOW0 && state_d != ST_HIGH0 &&
                 state_d != ST_LOW1 && state_d != ST_HIGH1) begin
      oe_d = 4'h0;
    end
  end

  // Read capture on the last cycle of each high phase; response pulse follows HIGH1.
  always_comb begin
    rd_hi_d = rd_hi_q;
    if (state_q == ST_HIGH0 && phase_done) rd_hi_d = io_qspi_qd_read;
    rsp_valid_d = (state_q == ST_HIGH1) && phase_done && !write_q;
    rsp_data_d  = rsp_valid_d ? {rd_hi_q, io_qspi_qd_read} : rsp_data_q;
  end

  // State and pin registers; reset returns the bus to idle at once.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_LOAD;
      write_q     <= 1'b0;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      rd_hi_q     <= 4'h0;
      qss_q       <= 1'b1;
      qck_q       <= 1'b0;
      qd_q        <= 4'h0;
      oe_q        <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      data_q      <= data_d;
      last_q      <= last_d;
      rd_hi_q     <= rd_hi_d;
      qss_q       <= qss_d;
      qck_q       <= qck_d;
      qd_q        <= qd_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_qspi_master.sv
// tb_qspi_master: two instances (CLK_DIV=2 and CLK_DIV=1) share one stimulus
// port; the selected one is compared every cycle against a timeline model that
// derives pin windows from the accept cycle with plain arithmetic.
`timescale 1ns/1ps
module tb_qspi_master;

  localparam int BIG = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       cmd_valid, cmd_write, cmd_last;
  logic [7:0] cmd_data;
  logic [3:0] qd_read = 4'h0;

  logic       a_ready, a_rsp_valid, a_busy, a_qss, a_qck;
  logic [7:0] a_rsp_data;
  logic [3:0] a_qd, a_oe;
  logic       b_ready, b_rsp_valid, b_busy, b_qss, b_qck;
  logic [7:0] b_rsp_data;
  logic [3:0] b_qd, b_oe;

  logic       m_ready, m_rsp_valid, m_busy, m_qss, m_qck;
  logic [7:0] m_rsp_data;
  logic [3:0] m_qd, m_oe;
  int         dv;

  always #5 clk = ~clk;

  qspi_master #(.CLK_DIV(2)) u_dut2 (
    .io_mainClk(clk), .io_asyncReset(rst),
    .io_cmd_valid(cmd_valid && !sel), .io_cmd_ready(a_ready),
    .io_cmd_write(cmd_write), .io_cmd_data(cmd_data), .io_cmd_last(cmd_last),
    .io_rsp_valid(a_rsp_valid), .io_rsp_data(a_rsp_data), .io_busy(a_busy),
    .io_qspi_qss(a_qss), .io_qspi_qck(a_qck),
    .io_qspi_qd_write(a_qd), .io_qspi_qd_writeEnable(a_oe),
    .io_qspi_qd_read(qd_read)
  );

  qspi_master #(.CLK_DIV(1)) u_dut1 (
    .io_mainClk(clk), .io_asyncReset(rst),
    .io_cmd_valid(cmd_valid && sel), .io_cmd_ready(b_ready),
    .io_cmd_write(cmd_write), .io_cmd_data(cmd_data), .io_cmd_last(cmd_last),
    .io_rsp_valid(b_rsp_valid), .io_rsp_data(b_rsp_data), .io_busy(b_busy),
    .io_qspi_qss(b_qss), .io_qspi_qck(b_qck),
    .io_qspi_qd_write(b_qd), .io_qspi_qd_writeEnable(b_oe),
    .io_qspi_qd_read(qd_read)
  );

  assign m_ready     = sel ? b_ready     : a_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_rsp_data  = sel ? b_rsp_data  : a_rsp_data;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_qss       = sel ? b_qss       : a_qss;
  assign m_qck       = sel ? b_qck       : a_qck;
  assign m_qd        = sel ? b_qd        : a_qd;
  assign m_oe        = sel ? b_oe        : a_oe;
  assign dv          = sel ? 1 : 2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Timeline model state: bs = first LOW0 cycle of the current byte.
  int         bs = -1;
  bit         sess_open = 0;
  int         sess_from = 0, sess_to = 0, ready_at = 0;
  bit         cur_w = 0;
  logic [7:0] cur_d = 8'h00, rbyte = 8'h00, exp_rsp = 8'h00;
  bit         force_en = 0;
  logic [7:0] force_rbyte = 8'h00;
  int         acc_cnt = 0, acc_cyc = 0;
  int         qck_rises = 0, rsp_pulses = 0, qss_run = 0, qss_last_run = 0;
  logic       prev_qck = 1'b0, prev_qss = 1'b1;

  bit         e_body, e_qck, e_rv, e_qss, e_ready;
  logic [3:0] e_oe;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bs = -1; sess_open = 0; sess_from = 0; sess_to = 0; ready_at = 0;
      exp_rsp = 8'h00; qss_run = 0;
      check_eq("rst_qss",       32'(m_qss), 32'd1);
      check_eq("rst_qck",       32'(m_qck), 32'd0);
      check_eq("rst_oe",        32'(m_oe), 32'd0);
      check_eq("rst_qd",        32'(m_qd), 32'd0);
      check_eq("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
      check_eq("rst_rsp_data",  32'(m_rsp_data), 32'd0);
      check_eq("rst_busy",      32'(m_busy), 32'd0);
    end else begin
      e_body  = (bs >= 0) && (cyc >= bs) && (cyc < bs + 4*dv);
      e_qck   = (bs >= 0) && ((cyc >= bs + dv   && cyc < bs + 2*dv) ||
                              (cyc >= bs + 3*dv && cyc < bs + 4*dv));
      e_oe    = (e_body && cur_w) ? 4'hF : 4'h0;
      e_rv    = (bs >= 0) && !cur_w && (cyc == bs + 4*dv);
      e_qss   = !(cyc >= sess_from && cyc < sess_to);
      e_ready = (cyc >= ready_at);
      if (e_rv) exp_rsp = rbyte;
      check_eq("qss",       32'(m_qss), 32'(e_qss));
      check_eq("busy",      32'(m_busy), 32'(!e_qss));
      check_eq("qck",       32'(m_qck), 32'(e_qck));
      check_eq("oe",        32'(m_oe), 32'(e_oe));
      check_eq("ready",     32'(m_ready), 32'(e_ready));
      check_eq("rsp_valid", 32'(m_rsp_valid), 32'(e_rv));
      check_eq("rsp_data",  32'(m_rsp_data), 32'(exp_rsp));
      if (e_oe != 4'h0)
        check_eq("qd", 32'(m_qd), 32'((cyc < bs + 2*dv) ? cur_d[7:4] : cur_d[3:0]));

      // Responder: correct nibble only on the final cycle of each high phase.
      if (bs >= 0 && !cur_w && cyc == bs + 2*dv - 1)      qd_read = rbyte[7:4];
      else if (bs >= 0 && !cur_w && cyc == bs + 4*dv - 1) qd_read = rbyte[3:0];
      else                                                qd_read = 4'($urandom);

      if (m_qck && !prev_qck) qck_rises++;
      if (m_rsp_valid) rsp_pulses++;
      if (!m_qss) qss_run++;
      else if (!prev_qss) begin qss_last_run = qss_run; qss_run = 0; end

      if (cmd_valid && e_ready) begin
        acc_cnt++;
        acc_cyc = cyc;
        if (!sess_open) begin sess_from = cyc + 1; bs = cyc + 1 + dv; end
        else bs = cyc + 1;
        cur_w = cmd_write;
        cur_d = cmd_data;
        rbyte = force_en ? force_rbyte : 8'($urandom);
        if (cmd_last) begin
          sess_open = 0; sess_to = bs + 5*dv; ready_at = bs + 5*dv;
        end else begin
          sess_open = 1; sess_to = BIG; ready_at = bs + 4*dv;
        end
      end
    end
    prev_qck = m_qck;
    prev_qss = m_qss;
  end

  // Offer one command (optionally scrambling the payload while it waits) and
  // return one cycle after it is taken, still at the input-drive point.
  task automatic send(input bit w, input logic [7:0] d, input bit l, input bit scr);
    int n0;
    bit done;
    cmd_valid = 1'b1; cmd_write = w; cmd_data = d; cmd_last = l;
    n0 = acc_cnt;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk); #1;
      if (acc_cnt != n0) done = 1;
      else begin
        @(posedge clk); #1;
        if (scr) begin cmd_write = 1'($urandom); cmd_data = 8'($urandom); end
      end
    end
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk); #1;
      if (!m_busy) ok = 1;
    end
    check_eq("idle_reached", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic random_phase(input int n);
    bit l;
    int gap;
    for (int i = 0; i < n; i++) begin
      l = (i == n - 1) || ($urandom_range(3) == 0);
      gap = $urandom_range(2);
      if (gap > 0) begin
        cmd_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      send(1'($urandom), 8'($urandom), l, 1'($urandom));
    end
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int r0, p0, a1, a2, a3;

  initial begin
    rst = 1'b1; sel = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_data = 8'h00; cmd_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single write 0xA5, CLK_DIV=2.
    r0 = qck_rises; p0 = rsp_pulses;
    send(1'b1, 8'hA5, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("wr_a5_qck_rises", 32'(qck_rises - r0), 32'd2);
    check_eq("wr_a5_qss_low",   32'(qss_last_run), 32'd12);
    check_eq("wr_a5_no_rsp",    32'(rsp_pulses - p0), 32'd0);

    // Single read, responder returns 0x3C.
    p0 = rsp_pulses;
    force_en = 1; force_rbyte = 8'h3C;
    send(1'b0, 8'hEE, 1'b1, 1'b0);
    force_en = 0;
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("rd_3c_pulses", 32'(rsp_pulses - p0), 32'd1);
    check_eq("rd_3c_data",   32'(m_rsp_data), 32'h3C);

    // Session: write 0x12 then read 0xF0 without releasing qss.
    send(1'b1, 8'h12, 1'b0, 1'b0);
    a1 = acc_cyc;
    force_en = 1; force_rbyte = 8'hF0;
    send(1'b0, 8'h00, 1'b1, 1'b0);
    force_en = 0;
    a2 = acc_cyc;
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("sess_accept_gap", 32'(a2 - a1), 32'd11);
    check_eq("sess_qss_low",    32'(qss_last_run), 32'd21);
    check_eq("sess_rsp_data",   32'(m_rsp_data), 32'hF0);

    // Backpressure: valid held throughout, payload changing every cycle.
    r0 = qck_rises; p0 = acc_cnt;
    send(1'b1, 8'h81, 1'b0, 1'b1);
    send(1'b0, 8'h42, 1'b1, 1'b1);
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("bp_accepts",   32'(acc_cnt - p0), 32'd2);
    check_eq("bp_qck_rises", 32'(qck_rises - r0), 32'd4);

    // Reset during HIGH0 of a read.
    send(1'b0, 8'h00, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 50 && !hit; k++) begin
        @(negedge clk); #1;
        if (m_qck) hit = 1;
      end
      check_eq("rst_high0_reached", 32'(hit), 32'd1);
    end
    p0 = rsp_pulses;
    rst = 1'b1;
    #1;
    check_eq("async_rst_qss",   32'(m_qss), 32'd1);
    check_eq("async_rst_qck",   32'(m_qck), 32'd0);
    check_eq("async_rst_oe",    32'(m_oe), 32'd0);
    check_eq("async_rst_rsp_v", 32'(m_rsp_valid), 32'd0);
    check_eq("async_rst_busy",  32'(m_busy), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    r0 = qck_rises;
    send(1'b1, 8'h5A, 1'b1, 1'b0);
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("post_rst_no_rsp",    32'(rsp_pulses - p0), 32'd0);
    check_eq("post_rst_qck_rises", 32'(qck_rises - r0), 32'd2);

    random_phase(80);

    // Switch to the CLK_DIV=1 instance.
    rst = 1'b1; sel = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Three-byte burst 0x01/0x02/0x03.
    r0 = qck_rises;
    send(1'b1, 8'h01, 1'b0, 1'b0); a1 = acc_cyc;
    send(1'b1, 8'h02, 1'b0, 1'b0); a2 = acc_cyc;
    send(1'b1, 8'h03, 1'b1, 1'b0); a3 = acc_cyc;
    cmd_valid = 1'b0;
    wait_idle();
    check_eq("div1_gap_first",  32'(a2 - a1), 32'd6);
    check_eq("div1_gap_byte",   32'(a3 - a2), 32'd5);
    check_eq("div1_qck_rises",  32'(qck_rises - r0), 32'd6);
    check_eq("div1_qss_low",    32'(qss_last_run), 32'd16);

    random_phase(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_master.md
# qspi_master

Quad-SPI initiator for the Murax peripheral bus, the controller-side counterpart of the existing QSPI analog responder. It lets the RISC-V core act as the controller on a 4-bit QSPI link: it drives QSS, QCK and QD toward an external responder, such as a second ice40 or the STM32 in slave mode. Transfers are one byte per command, split into two nibbles, high nibble first. It sits behind the APB bridge; the top level wraps `io_qspi_qd_*` in SB_IO tristate cells.

## Interface
- CLK_DIV, 4, QCK half-period in `io_mainClk` cycles; must be ≥1.
- io_mainClk  in  1  system clock; all logic on rising edge.
- io_asyncReset  in  1  asynchronous reset, active-high.
- io_cmd_valid  in  1  command offered.
- io_cmd_ready  out  1  command accepted when valid and ready are both high.
- io_cmd_write  in  1  1 = drive `io_cmd_data`; 0 = read a byte.
- io_cmd_data  in  8  byte to transmit; ignored for reads.
- io_cmd_last  in  1  1 = deassert QSS after this byte.
- io_rsp_valid  out  1  one-cycle pulse when read data is ready.
- io_rsp_data  out  8  last byte read; held until the next read completes.
- io_busy  out  1  high whenever the state is not IDLE.
- io_qspi_qss  out  1  select, active-low.
- io_qspi_qck  out  1  serial clock, idles low.
- io_qspi_qd_write  out  4  nibble driven to the pins.
- io_qspi_qd_writeEnable  out  4  per-bit output enable.
- io_qspi_qd_read  in  4  pin input.

## Operation
- Every pin output is registered, so pins are glitch-free.
- States: IDLE, SELECT, LOW0, HIGH0, LOW1, HIGH1, SEL_WAIT, DESELECT. Each state except IDLE and SEL_WAIT lasts exactly CLK_DIV cycles, timed by a down-counter of width clog2(CLK_DIV+1).
- IDLE
  - qss=1, qck=0, writeEnable=0, cmd_ready=1.
  - On accept: latch write, data and last; go to SELECT.
- SELECT: qss=0, qck=0; then go to LOW0.
- LOW0 / LOW1: qck=0.
  - If write: qd_write = data[7:4] (LOW0) or data[3:0] (LOW1), writeEnable=4'hF.
  - If read: writeEnable=0.
- HIGH0 / HIGH1: qck=1; qd_write and writeEnable hold their LOW-phase values.
- Read sampling: `io_qspi_qd_read` is captured on the last cycle of HIGH0 (into bits [7:4]) and the last cycle of HIGH1 (into bits [3:0]).
- After HIGH1:
  - writeEnable drops to 0 in the next cycle.
  - If read: rsp_data is updated and rsp_valid=1 for that single cycle.
  - If last=1: go to DESELECT. Otherwise go to SEL_WAIT.
- SEL_WAIT: qss=0, qck=0, cmd_ready=1. On accept go directly to LOW0; SELECT is skipped.
- DESELECT: qss=0, qck=0 for CLK_DIV cycles; then IDLE, where qss=1.
- cmd_ready is 0 in every other state. A command held valid while busy is neither dropped nor duplicated.
- Write commands never assert rsp_valid.

## Timing
- Reset values, applied immediately and asynchronously:
  - qss=1, qck=0, qd_write=0, writeEnable=0
  - rsp_valid=0, rsp_data=0x00, busy=0, state=IDLE
- Reset during a transfer aborts it: no rsp_valid pulse, and the bus returns to idle values with no extra QCK edge.
- Byte body (LOW0 through HIGH1) is 4·CLK_DIV cycles. QCK period is 2·CLK_DIV cycles.
- Single-byte transaction with last=1: qss is low for 6·CLK_DIV cycles, starting the cycle after accept.
- Back-to-back bytes in one session: 4·CLK_DIV+1 cycles per byte, with one SEL_WAIT cycle between bytes.
- QD changes only while qck=0, and only at LOW-phase entry, so data is stable for a full half-period before each rising edge.
- A new command accepted in the same cycle as an rsp_valid pulse is allowed; that pulse is unaffected.

## Test plan
- Write 0xA5, last=1, CLK_DIV=2:
  - qss falls 1 cycle after accept.
  - qd=0xA with writeEnable=F for 4 cycles, then 0x5 for 4 cycles.
  - exactly 2 QCK rising edges.
  - qss high again 12 cycles after leaving IDLE; no rsp_valid.
- Read, last=1, CLK_DIV=2, responder drives 0x3 during HIGH0 and 0xC during HIGH1:
  - writeEnable stays 0 throughout.
  - rsp_valid pulses once with rsp_data=0x3C.
- Session: write 0x12 (last=0), then read (last=1) with responder returning 0xF0:
  - qss stays low between bytes, with one SEL_WAIT cycle and no SELECT.
  - rsp_data=0xF0.
- Backpressure: io_cmd_valid held high through a transfer with a changing payload. Only the payload present in the SEL_WAIT or IDLE accept cycle is taken; exactly 2 bytes for 2 accepts.
- Reset asserted in HIGH0 of a read: outputs go to reset values immediately, no rsp_valid. After release, a fresh write of 0x5A completes correctly.
- CLK_DIV=1, three-byte burst 0x01/0x02/0x03 (last on the third):
  - QCK period 2 cycles.
  - 5 cycles per byte.
  - correct nibble order on QD.
